// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address and hands each
// registered instruction to decode over valid/ready. Optional perf counters under FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int                   PC_WIDTH    = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [6:0]           HALT_OPCODE = 7'b1111111
) (
  input  logic                clk_1,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic                fetch_valid,
  input  logic                fetch_ready,
  output logic [31:0]         fetch_instr,
  output logic [PC_WIDTH-1:0] fetch_pc,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall
`endif
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc, pc_next;
  logic                valid_next;
  logic [31:0]         instr_next;
  logic [PC_WIDTH-1:0] fpc_next;
  logic                accept;
  logic                load;

  assign imem_addr = pc;
  assign accept    = fetch_valid && fetch_ready;
  assign load      = !fetch_valid || fetch_ready;
  assign halted    = (state == HALTED);

  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_instr <= 32'h0;
      fetch_pc    <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      fetch_valid <= valid_next;
      fetch_instr <= instr_next;
      fetch_pc    <= fpc_next;
    end
  end

  // Redirect wins over everything and squashes whatever is on the outputs, even if accepted.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    valid_next = fetch_valid;
    instr_next = fetch_instr;
    fpc_next   = fetch_pc;
    if (redirect) begin
      pc_next    = redirect_pc;
      valid_next = 1'b0;
      state_next = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (load) begin
            instr_next = imem_rdata;
            fpc_next   = pc;
            valid_next = 1'b1;
            // The PC parks on the halt instruction so a frozen imem_addr points at it.
            if (imem_rdata[6:0] == HALT_OPCODE) begin
              state_next = HALT_PEND;
            end else begin
              pc_next = pc + PC_WIDTH'(1);
            end
          end
        end
        HALT_PEND: begin
          if (accept) begin
            valid_next = 1'b0;
            state_next = HALTED;
          end
        end
        HALTED: ;
        default: state_next = FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters; an accept squashed by a same-cycle redirect is not counted.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (accept && !redirect && (perf_fetched != 32'hFFFFFFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (fetch_valid && !fetch_ready && (perf_stall != 32'hFFFFFFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model plus a queue of expected fetch PCs.
// Perf counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

  localparam int PW = 4;

  logic          clk_1 = 1'b0;
  logic          rst_n;
  logic [PW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          fetch_valid;
  logic          fetch_ready;
  logic [31:0]   fetch_instr;
  logic [PW-1:0] fetch_pc;
  logic          redirect;
  logic [PW-1:0] redirect_pc;
  logic          halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_stall;
`endif

  logic [31:0]   mem [16];
  logic [PW-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk_1 = ~clk_1;

  assign imem_rdata = mem[imem_addr];

  instr_fetch_unit #(
    .PC_WIDTH    (PW),
    .RESET_PC    (4'h0),
    .HALT_OPCODE (7'h7F)
  ) dut (
    .clk_1       (clk_1),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  // Non-halt words with a distinct upper field per address and opcode 7'h13.
  function automatic logic [31:0] word_at(input int i);
    return 32'hC0DE_0013 + (32'(i) << 12);
  endfunction

  task automatic init_mem;
    for (int i = 0; i < 16; i++) mem[i] = word_at(i);
  endtask

  // Reset is released on a falling edge with decode ready, so the first load is the next rising edge.
  task automatic do_reset;
    rst_n       = 1'b0;
    fetch_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk_1);
    rst_n       = 1'b1;
    fetch_ready = 1'b1;
  endtask

  task automatic test_reset;
    init_mem();
    rst_n = 1'b0; fetch_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #3;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", fetch_valid); end
    checks++; if (fetch_pc !== 4'h0) begin errors++; $display("[TB] FAIL reset_fetch_pc got %0h want 0", fetch_pc); end
    checks++; if (fetch_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr got %08h want 0", fetch_instr); end
    checks++; if (imem_addr !== 4'h0) begin errors++; $display("[TB] FAIL reset_imem_addr got %0h want 0", imem_addr); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got %0b want 0", halted); end
  endtask

  task automatic test_sequential;
    logic [PW-1:0] e;
    init_mem();
    do_reset();
    exp_q = {};
    for (int i = 0; i < 4; i++) exp_q.push_back(PW'(i));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_1);
      checks++; if (fetch_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid cycle %0d got %0b want 1", i, fetch_valid); end
      e = exp_q.pop_front();
      checks++; if (fetch_pc !== e) begin errors++; $display("[TB] FAIL seq_pc got %0h want %0h", fetch_pc, e); end
      checks++; if (fetch_instr !== mem[e]) begin errors++; $display("[TB] FAIL seq_instr got %08h want %08h", fetch_instr, mem[e]); end
    end
  endtask

  task automatic test_stall;
    init_mem();
    do_reset();
    repeat (3) @(negedge clk_1);
    checks++; if (fetch_pc !== 4'h2) begin errors++; $display("[TB] FAIL stall_start_pc got %0h want 2", fetch_pc); end
    fetch_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_1);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 4'h2 || fetch_instr !== mem[2] || imem_addr !== 4'h3) begin
        errors++;
        $display("[TB] FAIL stall_hold cycle %0d got v=%0b pc=%0h instr=%08h addr=%0h want v=1 pc=2 instr=%08h addr=3",
                 k, fetch_valid, fetch_pc, fetch_instr, imem_addr, mem[2]);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_stall !== 32'd3) begin errors++; $display("[TB] FAIL perf_stall got %0d want 3", perf_stall); end
`endif
    fetch_ready = 1'b1;
    @(negedge clk_1);
    checks++; if (fetch_pc !== 4'h3) begin errors++; $display("[TB] FAIL stall_release_pc got %0h want 3", fetch_pc); end
    checks++; if (fetch_instr !== mem[3]) begin errors++; $display("[TB] FAIL stall_release_instr got %08h want %08h", fetch_instr, mem[3]); end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_fetched !== 32'd3) begin errors++; $display("[TB] FAIL perf_fetched got %0d want 3", perf_fetched); end
`endif
  endtask

  // Presented sequence 0..5, redirect while 5 is on the outputs, then A, B; 6 must never appear.
  task automatic test_redirect;
    logic [PW-1:0] e;
    init_mem();
    do_reset();
    exp_q = {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hA, 4'hB};
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      @(negedge clk_1);
      if (redirect) begin
        redirect = 1'b0;
        checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL redirect_squash got %0b want 0", fetch_valid); end
        checks++; if (imem_addr !== 4'hA) begin errors++; $display("[TB] FAIL redirect_addr got %0h want a", imem_addr); end
      end else if (fetch_valid) begin
        e = exp_q.pop_front();
        checks++; if (fetch_pc !== e) begin errors++; $display("[TB] FAIL redirect_seq_pc got %0h want %0h", fetch_pc, e); end
        checks++; if (fetch_instr !== mem[e]) begin errors++; $display("[TB] FAIL redirect_seq_instr got %08h want %08h", fetch_instr, mem[e]); end
        if (e == 4'h5) begin
          redirect    = 1'b1;
          redirect_pc = 4'hA;
        end
      end
    end
    redirect = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL redirect_timeout got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    logic [PW-1:0] e;
    init_mem();
    do_reset();
    @(negedge clk_1);
    redirect = 1'b1; redirect_pc = 4'hE;
    @(negedge clk_1);
    redirect = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_bubble got %0b want 0", fetch_valid); end
    exp_q = {4'hE, 4'hF, 4'h0, 4'h1};
    for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
      @(negedge clk_1);
      if (fetch_valid) begin
        e = exp_q.pop_front();
        checks++; if (fetch_pc !== e) begin errors++; $display("[TB] FAIL wrap_pc got %0h want %0h", fetch_pc, e); end
        checks++; if (fetch_instr !== mem[e]) begin errors++; $display("[TB] FAIL wrap_instr got %08h want %08h", fetch_instr, mem[e]); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL wrap_timeout got %0d pending want 0", exp_q.size()); end
  endtask

  task automatic test_halt;
    logic [PW-1:0] e;
    init_mem();
    mem[4] = 32'h0000007F;
    do_reset();
    exp_q = {4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    for (int cyc = 0; cyc < 15 && exp_q.size() > 0; cyc++) begin
      @(negedge clk_1);
      if (fetch_valid) begin
        e = exp_q.pop_front();
        checks++; if (fetch_pc !== e) begin errors++; $display("[TB] FAIL halt_seq_pc got %0h want %0h", fetch_pc, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL halt_timeout got %0d pending want 0", exp_q.size()); end
    checks++; if (fetch_instr !== 32'h0000007F) begin errors++; $display("[TB] FAIL halt_instr got %08h want 0000007f", fetch_instr); end
    checks++; if (imem_addr !== 4'h4) begin errors++; $display("[TB] FAIL halt_pc_frozen got %0h want 4", imem_addr); end
    fetch_ready = 1'b0;
    repeat (2) begin
      @(negedge clk_1);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 4'h4 || imem_addr !== 4'h4 || halted !== 1'b0) begin
        errors++;
        $display("[TB] FAIL halt_pend_hold got v=%0b pc=%0h addr=%0h h=%0b want v=1 pc=4 addr=4 h=0",
                 fetch_valid, fetch_pc, imem_addr, halted);
      end
    end
    fetch_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk_1);
      checks++;
      if (halted !== 1'b1 || fetch_valid !== 1'b0 || imem_addr !== 4'h4) begin
        errors++;
        $display("[TB] FAIL halted_state cycle %0d got h=%0b v=%0b addr=%0h want h=1 v=0 addr=4",
                 k, halted, fetch_valid, imem_addr);
      end
    end
    redirect = 1'b1; redirect_pc = 4'h0;
    @(negedge clk_1);
    redirect = 1'b0;
    checks++;
    if (halted !== 1'b0 || fetch_valid !== 1'b0 || imem_addr !== 4'h0) begin
      errors++;
      $display("[TB] FAIL halt_exit got h=%0b v=%0b addr=%0h want h=0 v=0 addr=0", halted, fetch_valid, imem_addr);
    end
    @(negedge clk_1);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 4'h0 || fetch_instr !== mem[0]) begin
      errors++;
      $display("[TB] FAIL halt_resume got v=%0b pc=%0h instr=%08h want v=1 pc=0 instr=%08h",
               fetch_valid, fetch_pc, fetch_instr, mem[0]);
    end
    init_mem();
  endtask

  // Reset dropped mid-cycle while the halt instruction is stalled; no clock edge occurs before the check.
  task automatic test_async_reset;
    int waited;
    init_mem();
    mem[4] = 32'h0000007F;
    do_reset();
    waited = 0;
    do begin
      @(negedge clk_1);
      waited++;
    end while (!(fetch_valid && fetch_pc == 4'h4) && waited < 15);
    checks++; if (!(fetch_valid && fetch_pc == 4'h4)) begin errors++; $display("[TB] FAIL async_wait_halt got pc=%0h want 4", fetch_pc); end
    fetch_ready = 1'b0;
    @(negedge clk_1);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (fetch_valid !== 1'b0 || fetch_pc !== 4'h0 || fetch_instr !== 32'h0 || imem_addr !== 4'h0 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got v=%0b pc=%0h instr=%08h addr=%0h h=%0b want all zero",
               fetch_valid, fetch_pc, fetch_instr, imem_addr, halted);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++; if (perf_stall !== 32'd0 || perf_fetched !== 32'd0) begin errors++; $display("[TB] FAIL async_perf got %0d/%0d want 0/0", perf_fetched, perf_stall); end
`endif
    init_mem();
    @(negedge clk_1);
    rst_n = 1'b1; fetch_ready = 1'b1;
    @(negedge clk_1);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 4'h0 || fetch_instr !== mem[0]) begin
      errors++;
      $display("[TB] FAIL async_restart got v=%0b pc=%0h instr=%08h want v=1 pc=0 instr=%08h",
               fetch_valid, fetch_pc, fetch_instr, mem[0]);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
